// File: rtl/stall_timer_pkg.sv
// Shared constants and types for the stall timer bank.
package stall_timer_pkg;

  localparam int DEFAULT_WIDTH    = 28;
  localparam int DEFAULT_CHANNELS = 4;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/stall_timer_channel.sv
// One down-counting stall timer: load, pause, cancel, one-shot or periodic
// reload, and a registered one-cycle expiry pulse.
module stall_timer_channel
  import stall_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_periodic,
  input  logic             pause,
  input  logic             cancel,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             mode_reg, mode_next;
  logic             expired_reg, expired_next;

  // State register; reset is active-low and overrides every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      reload_reg  <= '0;
      mode_reg    <= MODE_ONESHOT;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      reload_reg  <= reload_next;
      mode_reg    <= mode_next;
      expired_reg <= expired_next;
    end
  end

  // Next-state logic, priority load > cancel > decrement/expiry.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    reload_next  = reload_reg;
    mode_next    = mode_reg;
    expired_next = 1'b0;
    if (load) begin
      count_next  = load_value;
      reload_next = load_value;
      mode_next   = load_periodic;
      if (load_value == '0) begin
        // A zero-length stall completes at once.
        state_next   = ST_IDLE;
        expired_next = 1'b1;
      end else begin
        state_next = ST_RUN;
      end
    end else if (cancel) begin
      count_next = '0;
      state_next = ST_IDLE;
    end else if (state_reg == ST_RUN && !pause) begin
      if (count_reg > WIDTH'(1)) begin
        count_next = count_reg - WIDTH'(1);
      end else begin
        // Count of 1 (never 0 while running): this edge is the expiry.
        expired_next = 1'b1;
        if (mode_reg == MODE_PERIODIC) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = ST_IDLE;
        end
      end
    end
  end

  assign count   = count_reg;
  assign busy    = (state_reg == ST_RUN);
  assign expired = expired_reg;

endmodule

// File: rtl/stall_timer_bank.sv
// Bank of independent stall timers sharing one load port; per-channel
// pause/cancel, packed count outputs and a combined busy flag.
module stall_timer_bank
  import stall_timer_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic [CH_W-1:0]           load_ch,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      load_periodic,
  input  logic [CHANNELS-1:0]       pause,
  input  logic [CHANNELS-1:0]       cancel,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       expired,
  output logic                      any_busy
);

  logic [CHANNELS-1:0] load;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Out-of-range channel numbers match no channel and are dropped.
      assign load[gi] = load_valid && (int'(load_ch) == gi);

      stall_timer_channel #(
        .WIDTH(WIDTH)
      ) u_channel (
        .clk          (clk),
        .reset        (reset),
        .load         (load[gi]),
        .load_value   (load_value),
        .load_periodic(load_periodic),
        .pause        (pause[gi]),
        .cancel       (cancel[gi]),
        .count        (count[gi*WIDTH +: WIDTH]),
        .busy         (busy[gi]),
        .expired      (expired[gi])
      );
    end
  endgenerate

  assign any_busy = |busy;

endmodule

// File: tb/tb_stall_timer_bank.sv
// Self-checking bench for stall_timer_bank: directed vector table, multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_stall_timer_bank;

  localparam int W = 28;
  localparam int C = 4;

  logic           clk;
  logic           reset;
  logic           load_valid;
  logic [1:0]     load_ch;
  logic [W-1:0]   load_value;
  logic           load_periodic;
  logic [C-1:0]   pause;
  logic [C-1:0]   cancel;
  logic [C*W-1:0] count;
  logic [C-1:0]   busy;
  logic [C-1:0]   expired;
  logic           any_busy;

  // Second instance with a non-power-of-two channel count, so that an
  // out-of-range load_ch can actually be driven.
  logic           o_lv;
  logic [1:0]     o_ch;
  logic [7:0]     o_val;
  logic [2:0]     o_cancel;
  logic [23:0]    o_count;
  logic [2:0]     o_busy;
  logic [2:0]     o_exp;
  logic           o_any;

  stall_timer_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ch(load_ch),
    .load_value(load_value), .load_periodic(load_periodic), .pause(pause),
    .cancel(cancel), .count(count), .busy(busy), .expired(expired),
    .any_busy(any_busy)
  );

  stall_timer_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .load_valid(o_lv), .load_ch(o_ch),
    .load_value(o_val), .load_periodic(1'b0), .pause(3'b000),
    .cancel(o_cancel), .count(o_count), .busy(o_busy), .expired(o_exp),
    .any_busy(o_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: remaining cycles, reload length, mode, running, pulse.
  int unsigned m_cnt[C];
  int unsigned m_rel[C];
  bit          m_per[C];
  bit          m_run[C];
  bit          m_exp[C];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < C; c++) begin
      m_exp[c] = 1'b0;
      if (!reset) begin
        m_cnt[c] = 0; m_rel[c] = 0; m_per[c] = 1'b0; m_run[c] = 1'b0;
      end else if (load_valid && int'(load_ch) == c) begin
        m_cnt[c] = load_value;
        m_rel[c] = load_value;
        m_per[c] = load_periodic;
        m_run[c] = (load_value != 0);
        m_exp[c] = (load_value == 0);
      end else if (cancel[c]) begin
        m_cnt[c] = 0; m_run[c] = 1'b0;
      end else if (m_run[c] && !pause[c]) begin
        if (m_cnt[c] == 1) begin
          m_exp[c] = 1'b1;
          if (m_per[c]) m_cnt[c] = m_rel[c];
          else begin m_cnt[c] = 0; m_run[c] = 1'b0; end
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [C*W-1:0] ec;
    logic [C-1:0]   eb, ee;
    for (int c = 0; c < C; c++) begin
      ec[c*W +: W] = W'(m_cnt[c]);
      eb[c] = m_run[c];
      ee[c] = m_exp[c];
    end
    check("model count", 128'(count), 128'(ec));
    check("model busy", 128'(busy), 128'(eb));
    check("model expired", 128'(expired), 128'(ee));
    check("model any_busy", 128'(any_busy), 128'(|eb));
  endtask

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_model();
  endtask

  task automatic clear_in();
    load_valid = 1'b0; load_ch = '0; load_value = '0; load_periodic = 1'b0;
    pause = '0; cancel = '0;
    o_lv = 1'b0; o_ch = '0; o_val = '0; o_cancel = '0;
  endtask

  task automatic do_load(int ch, int unsigned val, bit per);
    load_valid = 1'b1; load_ch = 2'(ch); load_value = W'(val); load_periodic = per;
  endtask

  typedef struct {
    logic         lv;
    logic [1:0]   ch;
    logic [W-1:0] val;
    logic         per;
    logic [C-1:0] pa;
    logic [C-1:0] ca;
    int           chk;
    logic [W-1:0] e_cnt;
    logic         e_busy;
    logic         e_exp;
  } vec_t;

  function automatic vec_t mk(logic lv, logic [1:0] ch, logic [W-1:0] val, logic per,
                              logic [C-1:0] pa, logic [C-1:0] ca, int chk,
                              logic [W-1:0] ec, logic eb, logic ee);
    vec_t v;
    v.lv = lv; v.ch = ch; v.val = val; v.per = per; v.pa = pa; v.ca = ca;
    v.chk = chk; v.e_cnt = ec; v.e_busy = eb; v.e_exp = ee;
    return v;
  endfunction

  vec_t vecs[26];

  initial begin
    int first[C];
    int low_edge;
    logic [15:0] mask;
    logic [C-1:0] seen;

    // One-shot N=5 on ch0
    vecs[0]  = mk(1, 0, 5, 0, 4'b0000, 4'b0000, 0, 5, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 4, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 3, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    // N=0: single pulse, never busy
    vecs[7]  = mk(1, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    // Maximum value on ch1, then cancel with no pulse
    vecs[9]  = mk(1, 1, 28'hFFFFFFF, 0, 4'b0000, 4'b0000, 1, 28'hFFFFFFF, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 1, 28'hFFFFFFE, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    // Load in the would-be expiry cycle of ch3
    vecs[13] = mk(1, 3, 2, 0, 4'b0000, 4'b0000, 3, 2, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 3, 1, 1, 0);
    vecs[15] = mk(1, 3, 7, 0, 4'b0000, 4'b0000, 3, 7, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 3, 6, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 4'b0000, 4'b1000, 3, 0, 0, 0);
    // Load while paused on ch2, then cancel while paused
    vecs[18] = mk(1, 2, 4, 0, 4'b0100, 4'b0000, 2, 4, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 4'b0100, 4'b0000, 2, 4, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 2, 3, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 4'b0100, 4'b0100, 2, 0, 0, 0);
    // Periodic N=1 on ch0: pulse every cycle
    vecs[22] = mk(1, 0, 1, 1, 4'b0000, 4'b0000, 0, 1, 1, 0);
    vecs[23] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 1, 1);
    vecs[24] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 1, 1);
    vecs[25] = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0, 0);

    clear_in();
    reset = 1'b0;
    repeat (3) tick();
    check("reset count", 128'(count), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 26; i++) begin
      load_valid = vecs[i].lv; load_ch = vecs[i].ch; load_value = vecs[i].val;
      load_periodic = vecs[i].per; pause = vecs[i].pa; cancel = vecs[i].ca;
      tick();
      clear_in();
      check($sformatf("vec%0d count", i), 128'(count[vecs[i].chk*W +: W]), 128'(vecs[i].e_cnt));
      check($sformatf("vec%0d busy", i), 128'(busy[vecs[i].chk]), 128'(vecs[i].e_busy));
      check($sformatf("vec%0d expired", i), 128'(expired[vecs[i].chk]), 128'(vecs[i].e_exp));
    end

    // Periodic N=3 on ch2, paused at edges 4 and 5: pulses at 3, 8, 11, 14
    do_load(2, 3, 1'b1);
    tick();
    clear_in();
    mask = '0;
    for (int e = 1; e <= 15; e++) begin
      pause = (e == 4 || e == 5) ? 4'b0100 : 4'b0000;
      tick();
      if (expired[2]) mask[e] = 1'b1;
    end
    clear_in();
    check("periodic pause pulse edges", 128'(mask), 128'(16'h4908));
    cancel = '1; tick(); clear_in();

    // Independence: loads at edges 0..3 with N=2,3,5,7
    for (int c = 0; c < C; c++) first[c] = -1;
    low_edge = -1;
    for (int e = 0; e <= 14; e++) begin
      if (e == 0) do_load(0, 2, 1'b0);
      if (e == 1) do_load(1, 3, 1'b0);
      if (e == 2) do_load(2, 5, 1'b0);
      if (e == 3) do_load(3, 7, 1'b0);
      tick();
      clear_in();
      for (int c = 0; c < C; c++) if (expired[c] && first[c] < 0) first[c] = e;
      if (!any_busy && low_edge < 0) low_edge = e;
    end
    check("indep ch0 expiry edge", 128'(first[0]), 128'(2));
    check("indep ch1 expiry edge", 128'(first[1]), 128'(4));
    check("indep ch2 expiry edge", 128'(first[2]), 128'(7));
    check("indep ch3 expiry edge", 128'(first[3]), 128'(10));
    check("indep any_busy low edge", 128'(low_edge), 128'(10));

    // Reset mid-run overrides a simultaneous load
    do_load(0, 3, 1'b1); tick();
    do_load(1, 100, 1'b0); tick();
    clear_in(); tick();
    reset = 1'b0;
    do_load(2, 9, 1'b0);
    tick();
    clear_in();
    check("midrun reset count", 128'(count), 128'(0));
    check("midrun reset busy", 128'(busy), 128'(0));
    check("midrun reset expired", 128'(expired), 128'(0));
    reset = 1'b1;
    seen = '0;
    repeat (6) begin tick(); seen |= expired; end
    check("post reset stray expiry", 128'(seen), 128'(0));

    // Out-of-range channel on the 3-channel instance
    o_lv = 1'b1; o_ch = 2'd3; o_val = 8'd5;
    tick();
    clear_in();
    check("oob busy", 128'(o_busy), 128'(0));
    check("oob count", 128'(o_count), 128'(0));
    check("oob expired", 128'(o_exp), 128'(0));
    o_lv = 1'b1; o_ch = 2'd2; o_val = 8'd5;
    tick();
    clear_in();
    check("inrange busy", 128'(o_busy), 128'(3'b100));
    check("inrange count", 128'(o_count), 128'({8'd5, 16'd0}));
    o_cancel = 3'b111; tick(); clear_in();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      reset = ($urandom_range(0, 99) != 0);
      load_valid = ($urandom_range(0, 9) < 3);
      load_ch = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0) load_value = '0;
      else if (r == 1) load_value = W'(1);
      else if (r == 9) load_value = W'($urandom_range(0, 40));
      else load_value = W'($urandom_range(2, 12));
      load_periodic = $urandom_range(0, 1);
      pause = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cancel = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      tick();
    end
    clear_in();
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stall_timer_bank.md
# stall_timer_bank

Parametrised bank of independent down-counting stall timers for the drawing-robot processor. It replaces the single fixed 28-bit stall counter. Each channel loads a cycle count and decrements once per enabled cycle. A channel runs in one-shot or periodic mode, can be paused or cancelled, and raises a one-cycle expiry pulse. The processor stall logic and the stepper/servo pacing logic consume these pulses.

## Interface
Parameters:
- WIDTH, 28, counter width in bits.
- CHANNELS, 4, number of independent timers (≥1); CH_W = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: sampled on rising edge of clk, 0 = reset.
- load_valid  in  1  load request this cycle.
- load_ch  in  CH_W  target channel; values ≥ CHANNELS ignored.
- load_value  in  WIDTH  stall length N in cycles.
- load_periodic  in  1  0 = one-shot, 1 = periodic.
- pause  in  CHANNELS  per-channel hold; count frozen while 1.
- cancel  in  CHANNELS  per-channel abort.
- count  out  CHANNELS*WIDTH  current counts, channel c at bits [c*WIDTH +: WIDTH].
- busy  out  CHANNELS  channel running.
- expired  out  CHANNELS  one-cycle expiry pulse, registered.
- any_busy  out  1  OR of busy.

## Operation
- Per-channel state:
  - IDLE: busy=0.
  - RUN: busy=1.
  - Registers: count, reload, mode.
- Reset (reset=0 at an edge):
  - count=0, reload=0, mode=one-shot, busy=0, expired=0, any_busy=0.
  - Reset overrides every other input, including mid-run.
- Load (load_valid=1, load_ch=c < CHANNELS):
  - count=N, reload=N, mode=load_periodic.
  - N≠0 → RUN. N=0 → IDLE, with expired[c] pulsed next cycle (zero-length stall completes immediately).
- RUN, pause[c]=0:
  - count>1 → count−1.
  - count==1, one-shot → count=0, go IDLE, expired=1.
  - count==1, periodic → count=reload, stay RUN, expired=1.
- RUN, pause[c]=1: count, state and reload held; no expiry.
- cancel[c]=1:
  - count=0, IDLE, no expiry pulse.
  - Takes effect regardless of pause.
- Count never wraps below 0; no modulo arithmetic anywhere.
- Priority per channel: reset > load > cancel > decrement/expiry.
  - Load in the same cycle as a would-be expiry: load wins, no expiry pulse.
  - Load while paused: value is loaded, and the count stays frozen until pause drops.
  - Load to a running channel restarts it with the new N and mode.
- expired[c] is high for exactly one cycle per expiry event; otherwise 0.

## Timing
- Load sampled at edge 0 → count=N visible after edge 0 → decrements at edges 1..N.
- One-shot N≥1:
  - expired=1 and busy=0 in the cycle after edge N (count=0).
  - Total stall = N cycles from the load edge.
- Periodic N:
  - expired pulses after edges N, 2N, 3N…
  - Count sequence is N, N−1, …, 1, N, …
  - N=1 → expired high every cycle, count constant 1.
- Each paused cycle extends the stall by exactly one cycle.
- Cancel at edge k → busy=0 and count=0 after edge k.
- All outputs registered except any_busy, which is combinational OR of registered busy.
- No input-to-output combinational paths.

## Structure
- Package stall_timer_pkg holds:
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
  - state constants ST_IDLE, ST_RUN.
  - default WIDTH/CHANNELS.
- Sub-module stall_timer_channel: one WIDTH-bit channel (count/reload/mode/state, expiry pulse).
  - Ports: clk, reset, load, load_value, load_periodic, pause, cancel, count, busy, expired.
- stall_timer_bank: generate loop over CHANNELS, load_ch decode to per-channel load, output packing, any_busy OR.

## Test plan
- Reset: drive reset=0 mid-run on all channels → next cycle all count=0, busy=0, expired=0; no stray expiry after release.
- One-shot: load ch0 N=5 → count 5,4,3,2,1,0; expired[0] high only in the count=0 cycle (5 cycles after load edge); busy[0] low from then.
- Periodic with pause: load ch2 N=3 periodic; pause[2] for 2 cycles mid-period → expired[2] pulses delayed by exactly 2 cycles, then every 3 cycles.
- Edge values:
  - N=0 → single expired pulse next cycle, busy stays 0.
  - N=1 periodic → expired every cycle.
  - N=2^28−1 on ch1 → count=0x FFFFFFE after one cycle.
- Collisions:
  - Load ch3 N=7 in the cycle ch3 would expire → no pulse, count=7.
  - Cancel during RUN → count=0, no pulse.
  - Load with load_ch ≥ CHANNELS → no channel changes.
- Independence: run all channels with distinct N (2,3,5,7) concurrently → each expires on its own schedule; any_busy falls only after the last.
